// File: rtl/adder_tree_seq_ctrl.sv
// Sequencer in front of a shared registered adder tree: packs a word stream into lanes,
// enables the tree for TREE_LAT cycles, captures the sum and offers it on a valid/ready port.
module adder_tree_seq_ctrl #(
    parameter int W        = 32,
    parameter int LANES    = 33,
    parameter int RW       = 38,
    parameter int TREE_LAT = 2
) (
    input  logic                           clock,
    input  logic                           rst_n,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [W-1:0]                   s_data,
    input  logic                           s_last,
    output logic [LANES*W-1:0]             tree_data,
    output logic                           tree_ena,
    input  logic [RW-1:0]                  tree_result,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [RW-1:0]                  m_data,
    output logic [$clog2(LANES+1)-1:0]     m_count,
    output logic                           busy,
    output logic [1:0]                     dbg_state
);

    localparam int CW = $clog2(LANES + 1);
    localparam int LW = (TREE_LAT > 1) ? $clog2(TREE_LAT) : 1;

    // Handshakes: a word moves on s_valid && s_ready at the rising edge, a result
    // moves on m_valid && m_ready at the rising edge; neither side may retract valid.
    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_CAPT = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [CW-1:0]        r_count;
    logic [LW-1:0]        r_lat;
    logic [LANES*W-1:0]   r_lanes;
    logic [RW-1:0]        r_m_data;
    logic [CW-1:0]        r_m_count;
    logic                 w_accept;
    logic                 w_final;

    // s_ready is gated by rst_n so nothing is offered while reset is held.
    assign s_ready   = (r_state == ST_LOAD) && rst_n;
    assign w_accept  = s_valid && s_ready;
    assign w_final   = w_accept && (s_last || (r_count == CW'(LANES - 1)));
    assign tree_ena  = (r_state == ST_RUN);
    assign m_valid   = (r_state == ST_OUT);
    assign busy      = !((r_state == ST_LOAD) && (r_count == '0));
    assign tree_data = r_lanes;
    assign m_data    = r_m_data;
    assign m_count   = r_m_count;
    assign dbg_state = r_state;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_LOAD: if (w_final) w_next = ST_RUN;
            ST_RUN:  if (r_lat == '0) w_next = ST_CAPT;
            ST_CAPT: w_next = ST_OUT;
            ST_OUT:  if (m_ready) w_next = ST_LOAD;
            default: w_next = ST_LOAD;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_lat     <= '0;
            r_lanes   <= '0;
            r_m_data  <= '0;
            r_m_count <= '0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_accept) begin
                        for (int k = 0; k < LANES; k++) begin
                            if (r_count == CW'(k)) r_lanes[k*W +: W] <= s_data;
                        end
                        r_count <= r_count + 1'b1;
                    end
                    if (w_final) r_lat <= LW'(TREE_LAT - 1);
                end
                ST_RUN: begin
                    if (r_lat != '0) r_lat <= r_lat - 1'b1;
                end
                ST_CAPT: begin
                    r_m_data  <= tree_result;
                    r_m_count <= r_count;
                end
                ST_OUT: begin
                    // Lanes are cleared here so unused lanes of the next transaction read 0.
                    if (m_ready) begin
                        r_count <= '0;
                        r_lanes <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_tree_seq_ctrl.sv
// Bench for adder_tree_seq_ctrl: a behavioural tree stub, directed transactions with literal
// expectations, random transactions, and one negedge compare process against a stream-level model.
module tb_adder_tree_seq_ctrl;

    localparam int W        = 32;
    localparam int LANES    = 33;
    localparam int RW       = 38;
    localparam int TREE_LAT = 2;
    localparam int CW       = $clog2(LANES + 1);
    localparam int DW       = LANES * W;

    logic            clock;
    logic            rst_n;
    logic            s_valid;
    logic            s_ready;
    logic [W-1:0]    s_data;
    logic            s_last;
    logic [DW-1:0]   tree_data;
    logic            tree_ena;
    logic [RW-1:0]   tree_result;
    logic            m_valid;
    logic            m_ready;
    logic [RW-1:0]   m_data;
    logic [CW-1:0]   m_count;
    logic            busy;
    logic [1:0]      dbg_state;

    adder_tree_seq_ctrl #(.W(W), .LANES(LANES), .RW(RW), .TREE_LAT(TREE_LAT)) dut (
        .clock(clock), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .tree_data(tree_data), .tree_ena(tree_ena), .tree_result(tree_result),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_count(m_count),
        .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- external tree stub ----------------
    logic [RW-1:0] t_pipe [TREE_LAT];

    function automatic logic [RW-1:0] lane_sum(input logic [DW-1:0] d);
        logic [RW-1:0] s = '0;
        for (int k = 0; k < LANES; k++) s += RW'(d[k*W +: W]);
        return s;
    endfunction

    always @(posedge clock) begin
        if (tree_ena) begin
            t_pipe[0] <= lane_sum(tree_data);
            for (int i = 1; i < TREE_LAT; i++) t_pipe[i] <= t_pipe[i-1];
        end
    end
    assign tree_result = t_pipe[TREE_LAT-1];

    // ---------------- m_ready source ----------------
    logic rand_mode;
    logic drv_ready;
    logic rnd_ready;
    assign m_ready = rand_mode ? rnd_ready : drv_ready;

    initial begin
        rnd_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            rnd_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- driver state shared with the compare process ----------------
    logic [W-1:0]  txn_w [LANES];
    int            drv_timeouts;
    bit            done;
    int            lit_set;
    logic [RW-1:0] lit_data;
    logic [CW-1:0] lit_count;
    int            lit_hi;

    // ---------------- scoreboard / model ----------------
    logic [RW-1:0] exp_q [$];
    logic [CW-1:0] cnt_q [$];
    logic [W-1:0]  mdl_words [LANES];
    int            mdl_n;
    bit            pending;
    logic [DW-1:0] mdl_packed;
    logic [RW-1:0] mdl_sum;
    logic [DW-1:0] hi_bits;
    int            ena_cnt;
    int            neg_cnt;
    int            exp_valid_neg;
    bit            prev_m_valid;
    int            n_results;
    int            lit_done;
    int            n_cmp;
    int            n_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_lanes(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            for (int k = 0; k < LANES; k++) begin
                if (act[k*W +: W] !== exp[k*W +: W]) begin
                    $display("FAIL %s: lane %0d got 0x%0h expected 0x%0h (t=%0t)",
                             name, k, act[k*W +: W], exp[k*W +: W], $time);
                    break;
                end
            end
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0; n_results = 0; lit_done = 0;
        mdl_n = 0; pending = 0; ena_cnt = 0; neg_cnt = 0; exp_valid_neg = 0; prev_m_valid = 0;
        mdl_packed = '0;
    end

    always @(negedge clock) begin
        neg_cnt++;
        if (done) begin
            chk("driver_timeouts", 64'(drv_timeouts), 64'd0);
            chk("results_received", 64'(n_results), 64'd206);
            chk("queue_drained", 64'(exp_q.size()), 64'd0);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
            $finish;
        end else if (!rst_n) begin
            chk("rst_s_ready", 64'(s_ready), 64'd0);
            chk("rst_m_valid", 64'(m_valid), 64'd0);
            chk("rst_tree_ena", 64'(tree_ena), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_m_data", 64'(m_data), 64'd0);
            chk("rst_m_count", 64'(m_count), 64'd0);
            chk("rst_state", 64'(dbg_state), 64'd0);
            chk_lanes("rst_tree_data", tree_data, '0);
            exp_q.delete();
            cnt_q.delete();
            pending = 0; mdl_n = 0; ena_cnt = 0; prev_m_valid = 0;
        end else begin
            chk("s_ready", 64'(s_ready), 64'(!pending));
            chk("busy", 64'(busy), 64'(pending || (mdl_n != 0)));
            if (tree_ena) begin
                chk("ena_only_in_run", 64'(pending && !m_valid && (ena_cnt < TREE_LAT)), 64'd1);
                chk_lanes("tree_data", tree_data, mdl_packed);
                if (lit_set != lit_done && lit_hi < LANES) begin
                    hi_bits = tree_data >> (lit_hi * W);
                    chk("lit_zero_fill", 64'(hi_bits == '0), 64'd1);
                end
                ena_cnt++;
            end
            if (m_valid && !prev_m_valid) begin
                chk("latency", 64'(neg_cnt), 64'(exp_valid_neg));
                chk("ena_cycles", 64'(ena_cnt), 64'(TREE_LAT));
            end
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_m_valid", 64'(m_valid), 64'd0);
                end else begin
                    chk("m_data", 64'(m_data), 64'(exp_q[0]));
                    chk("m_count", 64'(m_count), 64'(cnt_q[0]));
                    if (m_ready) begin
                        if (lit_set != lit_done) begin
                            chk("lit_m_data", 64'(m_data), 64'(lit_data));
                            chk("lit_m_count", 64'(m_count), 64'(lit_count));
                            lit_done = lit_set;
                        end
                        void'(exp_q.pop_front());
                        void'(cnt_q.pop_front());
                        pending = 0;
                        n_results++;
                    end
                end
            end
            if (s_valid && s_ready) begin
                mdl_words[mdl_n] = s_data;
                mdl_n++;
                if (s_last || mdl_n == LANES) begin
                    mdl_packed = '0;
                    mdl_sum = '0;
                    for (int k = 0; k < mdl_n; k++) begin
                        mdl_packed[k*W +: W] = mdl_words[k];
                        mdl_sum += RW'(mdl_words[k]);
                    end
                    exp_q.push_back(mdl_sum);
                    cnt_q.push_back(CW'(mdl_n));
                    pending = 1;
                    mdl_n = 0;
                    ena_cnt = 0;
                    exp_valid_neg = neg_cnt + TREE_LAT + 2;
                end
            end
            prev_m_valid = m_valid;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_word(input logic [W-1:0] d, input logic last, input int gap);
        int t;
        s_valid = 1'b0;
        repeat (gap) tick();
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        t = 0;
        forever begin
            @(negedge clock);
            if (s_ready) break;
            t++;
            if (t > 300) begin
                drv_timeouts++;
                break;
            end
        end
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_txn(input int n, input bit use_last, input bit rand_gaps);
        for (int i = 0; i < n; i++)
            send_word(txn_w[i], use_last && (i == n - 1), rand_gaps ? int'($urandom_range(0, 2)) : 0);
    endtask

    task automatic wait_results(input int target);
        for (int t = 0; t < 400; t++) begin
            if (n_results >= target) return;
            tick();
        end
        drv_timeouts++;
    endtask

    task automatic set_lit(input logic [RW-1:0] d, input logic [CW-1:0] c, input int hi);
        lit_data  = d;
        lit_count = c;
        lit_hi    = hi;
        lit_set++;
    endtask

    task automatic load_t3();
        txn_w[0] = 32'd10;
        txn_w[1] = 32'd20;
        txn_w[2] = 32'd30;
    endtask

    // ---------------- directed and random stimulus ----------------
    initial begin
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        drv_ready = 1'b1; rand_mode = 1'b0; done = 1'b0;
        drv_timeouts = 0; lit_set = 0; lit_hi = LANES; lit_data = '0; lit_count = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // T1: full 33 words of all-ones, no s_last
        for (int i = 0; i < LANES; i++) txn_w[i] = 32'hFFFF_FFFF;
        set_lit(38'h20_FFFF_FFDF, 6'd33, LANES);
        send_txn(LANES, 1'b0, 1'b0);
        wait_results(1);

        // T2: 1..33 with s_last on word 33
        for (int i = 0; i < LANES; i++) txn_w[i] = 32'(i + 1);
        set_lit(38'd561, 6'd33, LANES);
        send_txn(LANES, 1'b1, 1'b0);
        wait_results(2);

        // T3: short transaction, upper lanes must be zero
        load_t3();
        set_lit(38'd60, 6'd3, 3);
        send_txn(3, 1'b1, 1'b0);
        wait_results(3);

        // T4: T3 under result backpressure, then an immediate follow-up stream
        drv_ready = 1'b0;
        set_lit(38'd60, 6'd3, 3);
        send_txn(3, 1'b1, 1'b0);
        repeat (8) tick();
        drv_ready = 1'b1;
        wait_results(4);
        set_lit(38'd60, 6'd3, 3);
        send_txn(3, 1'b1, 1'b0);
        wait_results(5);

        // T5: reset pulse during RUN of T2, then T3
        for (int i = 0; i < LANES; i++) txn_w[i] = 32'(i + 1);
        send_txn(LANES, 1'b1, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        load_t3();
        set_lit(38'd60, 6'd3, 3);
        send_txn(3, 1'b1, 1'b0);
        wait_results(6);

        // T6: random lengths, gaps and result backpressure
        rand_mode = 1'b1;
        for (int t = 0; t < 200; t++) begin
            int n;
            bit use_last;
            n = int'($urandom_range(1, LANES));
            use_last = (n < LANES) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) txn_w[i] = $urandom;
            send_txn(n, use_last, 1'b1);
        end
        wait_results(206);
        rand_mode = 1'b0;
        repeat (3) tick();
        done = 1'b1;
    end

endmodule
